codec_intf: RTL and testbench

Serial codec boundary for the guitar effects chain. It generates the codec clocks (MCLK, BCLK, LRCLK) from the system clock and deserializes I2S ADC data into parallel 16-bit left/right samples with a one-cycle VALID strobe for the effect core. It also serializes the effect core's processed left/right samples back to the codec DAC.

---
 rtl/codec_intf_if.sv | 24 ++
 rtl/codec_intf.sv | 83 ++++++++
 tb/tb_codec_intf.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/codec_intf_if.sv
// Signal bundle between the codec boundary block and the effect core / codec pins.
// The master modport is the codec_intf side; slave is the side that consumes it.
interface codec_intf_if;
  logic        MCLK;
  logic        BCLK;
  logic        LRCLK;
  logic        ADCDAT;
  logic        DACDAT;
  logic [15:0] left_rx;
  logic [15:0] right_rx;
  logic        VALID;
  logic [15:0] left_tx;
  logic [15:0] right_tx;

  modport master (
    output MCLK, BCLK, LRCLK, DACDAT, left_rx, right_rx, VALID,
    input  ADCDAT, left_tx, right_tx
  );

  modport slave (
    input  MCLK, BCLK, LRCLK, DACDAT, left_rx, right_rx, VALID,
    output ADCDAT, left_tx, right_tx
  );
endinterface

// File: rtl/codec_intf.sv
// I2S codec boundary: clock generation from one free-running counter, ADC
// deserialization into 16-bit L/R words with a VALID strobe, and DAC serialization.
module codec_intf (
  input  logic         clk,
  input  logic         rst_n,
  codec_intf_if.master bus
);

  logic [9:0]  cnt;
  logic [9:0]  cnt_nxt;
  logic [15:0] rx_shift;
  logic [15:0] rx_hold;
  logic [15:0] rx_word;
  logic [15:0] tx_l;
  logic [15:0] tx_r;
  logic [15:0] left_rx_q;
  logic [15:0] right_rx_q;
  logic        valid_q;
  logic        dac_q;
  logic        rx_slot;

  // Data bits live in slots 1..16 of each half-frame (I2S one-slot MSB delay).
  function automatic logic in_data_slot(input logic [4:0] slot);
    return (slot >= 5'd1) && (slot <= 5'd16);
  endfunction

  function automatic logic tx_bit(input logic [15:0] word, input logic [4:0] slot);
    logic [3:0] idx;
    idx = 4'(5'd16 - slot);
    if (in_data_slot(slot))
      return word[idx];
    return 1'b0;
  endfunction

  assign cnt_nxt = cnt + 10'd1;
  assign rx_slot = in_data_slot(cnt[8:4]);
  assign rx_word = {rx_shift[14:0], bus.ADCDAT};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      rx_shift   <= '0;
      rx_hold    <= '0;
      tx_l       <= '0;
      tx_r       <= '0;
      left_rx_q  <= '0;
      right_rx_q <= '0;
      valid_q    <= 1'b0;
      dac_q      <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      valid_q <= 1'b0;

      // Receive: sample on the last clk before BCLK rises.
      if ((cnt[3:0] == 4'h7) && rx_slot)
        rx_shift <= rx_word;
      if (cnt == 10'h107)
        rx_hold <= rx_word;
      if (cnt == 10'h307) begin
        left_rx_q  <= rx_hold;
        right_rx_q <= rx_word;
        valid_q    <= 1'b1;
      end

      // Transmit: latch once per frame, shift out as BCLK falls.
      if (cnt == 10'h3FF) begin
        tx_l <= bus.left_tx;
        tx_r <= bus.right_tx;
      end
      if (cnt[3:0] == 4'hF)
        dac_q <= tx_bit(cnt_nxt[9] ? tx_r : tx_l, cnt_nxt[8:4]);
    end
  end

  assign bus.MCLK     = cnt[1];
  assign bus.BCLK     = cnt[3];
  assign bus.LRCLK    = cnt[9];
  assign bus.DACDAT   = dac_q;
  assign bus.left_rx  = left_rx_q;
  assign bus.right_rx = right_rx_q;
  assign bus.VALID    = valid_q;

endmodule

// File: tb/tb_codec_intf.sv
// Directed bench for codec_intf: a codec model driven from the bench's own frame
// counter, DAC capture at BCLK rising edges, and frame-level checks.
module tb_codec_intf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  codec_intf_if bus();

  codec_intf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  mcnt;
  logic [15:0] adc_l, adc_r;
  logic [15:0] cap_l, cap_r;
  logic [15:0] prev_l, prev_r;
  logic        loop;
  int tick_idx, valid_edge, n_valid, vld_err, zero_err, stab_err, clk_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_acc();
    tick_idx   = 0;
    valid_edge = -1;
    n_valid    = 0;
    vld_err    = 0;
    zero_err   = 0;
    stab_err   = 0;
    clk_err    = 0;
    cap_l      = '0;
    cap_r      = '0;
  endtask

  // One clk: advance model counter, observe DUT, then drive the next ADC bit.
  task automatic tick();
    int b;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mcnt   = '0;
      prev_l = bus.left_rx;
      prev_r = bus.right_rx;
    end else begin
      mcnt = mcnt + 10'd1;
      tick_idx++;
      if (bus.VALID !== (mcnt == 10'h308)) vld_err++;
      if (bus.VALID === 1'b1) begin
        n_valid++;
        valid_edge = tick_idx;
      end
      if (bus.VALID !== 1'b1 && (bus.left_rx !== prev_l || bus.right_rx !== prev_r))
        stab_err++;
      prev_l = bus.left_rx;
      prev_r = bus.right_rx;
      if ({bus.LRCLK, bus.BCLK, bus.MCLK} !== {mcnt[9], mcnt[3], mcnt[1]}) clk_err++;
      if (mcnt[3:0] == 4'h8) begin
        b = int'(mcnt[8:4]);
        if (b >= 1 && b <= 16) begin
          if (mcnt[9]) cap_r[16-b] = bus.DACDAT;
          else         cap_l[16-b] = bus.DACDAT;
        end else if (bus.DACDAT !== 1'b0) begin
          zero_err++;
        end
      end
    end
    b = int'(mcnt[8:4]);
    if (loop)
      bus.ADCDAT = bus.DACDAT;
    else if (b >= 1 && b <= 16)
      bus.ADCDAT = mcnt[9] ? adc_r[16-b] : adc_l[16-b];
    else
      bus.ADCDAT = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.ADCDAT   = 1'b0;
    bus.left_tx  = 16'h0000;
    bus.right_tx = 16'h0000;
    loop  = 1'b0;
    mcnt  = '0;
    adc_l = 16'hA5C3;
    adc_r = 16'h8001;
    prev_l = '0;
    prev_r = '0;
    clear_acc();

    // Reset held for 5 clks
    run(5);
    chk("rst_mclk",   32'(bus.MCLK),     32'd0);
    chk("rst_bclk",   32'(bus.BCLK),     32'd0);
    chk("rst_lrclk",  32'(bus.LRCLK),    32'd0);
    chk("rst_dacdat", 32'(bus.DACDAT),   32'd0);
    chk("rst_valid",  32'(bus.VALID),    32'd0);
    chk("rst_left",   32'(bus.left_rx),  32'd0);
    chk("rst_right",  32'(bus.right_rx), 32'd0);

    // Frame 0: first VALID timing, receive pattern, transmit zeros
    rst_n = 1'b1;
    bus.left_tx  = 16'h1234;
    bus.right_tx = 16'hFEDC;
    clear_acc();
    run(1024);
    chk("f0_valid_edge", 32'(valid_edge), 32'd776);
    chk("f0_n_valid",    32'(n_valid),    32'd1);
    chk("f0_vld_err",    32'(vld_err),    32'd0);
    chk("f0_left_rx",    32'(bus.left_rx),  32'h0000A5C3);
    chk("f0_right_rx",   32'(bus.right_rx), 32'h00008001);
    chk("f0_tx_left",    32'(cap_l), 32'd0);
    chk("f0_tx_right",   32'(cap_r), 32'd0);
    chk("f0_zero_slots", 32'(zero_err), 32'd0);
    chk("f0_stable",     32'(stab_err), 32'd0);
    chk("f0_clocks",     32'(clk_err),  32'd0);

    // Frame 1: transmit latched pattern, receive a new pattern
    adc_l = 16'h5A3C;
    adc_r = 16'h7FFE;
    clear_acc();
    run(1024);
    chk("f1_tx_left",    32'(cap_l), 32'h00001234);
    chk("f1_tx_right",   32'(cap_r), 32'h0000FEDC);
    chk("f1_zero_slots", 32'(zero_err), 32'd0);
    chk("f1_valid_edge", 32'(valid_edge), 32'd776);
    chk("f1_vld_err",    32'(vld_err),  32'd0);
    chk("f1_left_rx",    32'(bus.left_rx),  32'h00005A3C);
    chk("f1_right_rx",   32'(bus.right_rx), 32'h00007FFE);
    chk("f1_stable",     32'(stab_err), 32'd0);

    // Frame 2: left_tx changes mid-frame; this frame still sends frame-1 latch
    bus.left_tx = 16'h0F0F;
    clear_acc();
    run(10'h100);
    bus.left_tx = 16'hF0F0;
    run(10'h300);
    chk("f2_tx_left",  32'(cap_l), 32'h00001234);
    chk("f2_tx_right", 32'(cap_r), 32'h0000FEDC);

    // Frame 3: sends value held at the latch; change just before and just after it
    clear_acc();
    run(10'h3FF);
    bus.left_tx = 16'h3C3C;
    run(1);
    chk("f3_tx_left",  32'(cap_l), 32'h0000F0F0);
    chk("f3_tx_right", 32'(cap_r), 32'h0000FEDC);
    chk("f3_zero_slots", 32'(zero_err), 32'd0);
    bus.left_tx  = 16'h7FFF;
    bus.right_tx = 16'h8000;
    loop = 1'b1;

    // Frame 4: loopback of the pre-edge latched value
    clear_acc();
    run(1024);
    chk("f4_tx_left",  32'(cap_l), 32'h00003C3C);
    chk("f4_tx_right", 32'(cap_r), 32'h0000FEDC);
    chk("f4_left_rx",  32'(bus.left_rx),  32'h00003C3C);
    chk("f4_right_rx", 32'(bus.right_rx), 32'h0000FEDC);

    // Frame 5: loopback of 7FFF/8000
    clear_acc();
    run(1024);
    chk("f5_tx_left",  32'(cap_l), 32'h00007FFF);
    chk("f5_tx_right", 32'(cap_r), 32'h00008000);
    chk("f5_left_rx",  32'(bus.left_rx),  32'h00007FFF);
    chk("f5_right_rx", 32'(bus.right_rx), 32'h00008000);
    chk("f5_vld_err",  32'(vld_err), 32'd0);

    // Frame 6: asynchronous reset at cnt 0x150
    loop  = 1'b0;
    adc_l = 16'h1357;
    adc_r = 16'h2468;
    clear_acc();
    run(10'h150);
    rst_n = 1'b0;
    #1;
    chk("mrst_left",   32'(bus.left_rx),  32'd0);
    chk("mrst_right",  32'(bus.right_rx), 32'd0);
    chk("mrst_dacdat", 32'(bus.DACDAT),   32'd0);
    chk("mrst_valid",  32'(bus.VALID),    32'd0);
    chk("mrst_lrclk",  32'(bus.LRCLK),    32'd0);
    run(3);
    rst_n = 1'b1;
    clear_acc();
    run(1024);
    chk("post_valid_edge", 32'(valid_edge), 32'd776);
    chk("post_n_valid",    32'(n_valid),    32'd1);
    chk("post_vld_err",    32'(vld_err),    32'd0);
    chk("post_left_rx",    32'(bus.left_rx),  32'h00001357);
    chk("post_right_rx",   32'(bus.right_rx), 32'h00002468);
    chk("post_tx_left",    32'(cap_l), 32'd0);
    chk("post_tx_right",   32'(cap_r), 32'd0);
    chk("post_zero_slots", 32'(zero_err), 32'd0);
    chk("post_stable",     32'(stab_err), 32'd0);
    chk("post_clocks",     32'(clk_err),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
